projectile_pool_ctrl: RTL

PROJECTILE_POOL_CTRL -- requirements
Module: projectile_pool_ctrl

---
 rtl/projectile_pool_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/projectile_pool_ctrl.sv
// Projectile pool controller: player/alien slot allocation,
// refire cooldown and alien shooter column/row scan.
module projectile_pool_ctrl #(
  parameter int N_PLAYER     = 2,
  parameter int N_ALIEN      = 3,
  parameter int GRID_COLS    = 14,
  parameter int GRID_ROWS    = 6,
  parameter int CELL         = 32,
  parameter int PLAYER_XOFF  = 32,
  parameter int PLAYER_SPEED = -192,
  parameter int COOLDOWN     = 4
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                playerFire,
  input  logic signed [10:0]  playerTLX,
  input  logic signed [10:0]  playerTLY,
  input  logic                shootPulse,
  input  logic [3:0]          randCol,
  input  logic [1:0]          randSpeed,
  input  logic                alienPresent,
  input  logic signed [10:0]  aliensTLX,
  input  logic signed [10:0]  aliensTLY,
  input  logic [N_PLAYER-1:0] pKill,
  input  logic [N_ALIEN-1:0]  aKill,
  output logic [3:0]          colIdx,
  output logic [2:0]          rowIdx,
  output logic [N_PLAYER-1:0] activePlayer,
  output logic [N_ALIEN-1:0]  activeAlien,
  output logic                spawnValid,
  output logic                spawnIsAlien,
  output logic [2:0]          spawnIdx,
  output logic signed [10:0]  initialX,
  output logic signed [10:0]  initialY,
  output logic signed [10:0]  initialSpeed,
  output logic                scanBusy
);

  localparam logic [4:0] COLS5 = 5'(GRID_COLS);
  localparam logic [3:0] COL_LAST = 4'(GRID_COLS - 1);
  localparam logic [2:0] ROW_TOP = 3'(GRID_ROWS - 1);
  localparam logic [7:0] CELLS8 = 8'(GRID_COLS * GRID_ROWS);
  localparam logic [7:0] CD_RELOAD = 8'(COOLDOWN);
  localparam logic signed [10:0] XOFF11 = 11'(PLAYER_XOFF);
  localparam logic signed [10:0] PSPD11 = 11'(PLAYER_SPEED);
  localparam logic signed [10:0] CELL11 = 11'(CELL);
  localparam logic signed [10:0] HALF11 = 11'(CELL / 2);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state_q, state_d;

  logic [3:0] col_d;
  logic [2:0] row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cd_q;

  logic       p_free, a_free;
  logic [2:0] p_idx, a_idx;
  logic       p_go, a_go;

  logic [N_PLAYER-1:0] p_set;
  logic [N_ALIEN-1:0]  a_set;

  logic signed [10:0] px, ax, ay, aspd;

  // lowest-index free player slot, from start-of-cycle flags
  always_comb begin
    p_free = 1'b0;
    p_idx  = 3'd0;
    for (int i = N_PLAYER - 1; i >= 0; i--) begin
      if (!activePlayer[i]) begin
        p_free = 1'b1;
        p_idx  = 3'(i);
      end
    end
  end

  // lowest-index free alien slot, from start-of-cycle flags
  always_comb begin
    a_free = 1'b0;
    a_idx  = 3'd0;
    for (int i = N_ALIEN - 1; i >= 0; i--) begin
      if (!activeAlien[i]) begin
        a_free = 1'b1;
        a_idx  = 3'(i);
      end
    end
  end

  assign p_go = playerFire && p_free && (cd_q == 8'd0);

  assign p_set = p_go ? (N_PLAYER'(1) << p_idx) : '0;
  assign a_set = a_go ? (N_ALIEN'(1) << a_idx) : '0;

  // spawn coordinates, wrapping 11-bit signed arithmetic
  always_comb begin
    px   = playerTLX + XOFF11;
    ax   = aliensTLX + CELL11 * $signed({7'd0, colIdx}) + HALF11;
    ay   = aliensTLY + CELL11 * $signed({8'd0, rowIdx}) + CELL11;
    aspd = $signed({2'b00, {1'b0, randSpeed} + 3'd1, 6'd0});
  end

  // scan FSM next state; a player spawn stalls a hit for a cycle
  always_comb begin
    state_d = state_q;
    col_d   = colIdx;
    row_d   = rowIdx;
    cnt_d   = cnt_q;
    a_go    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (shootPulse && a_free) begin
          state_d = SCAN;
          col_d   = ({1'b0, randCol} >= COLS5) ? 4'd0 : randCol;
          row_d   = ROW_TOP;
          cnt_d   = 8'd0;
        end
      end
      SCAN: begin
        if (alienPresent) begin
          if (!p_go) begin
            state_d = IDLE;
            a_go    = a_free;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (rowIdx == 3'd0) begin
            row_d = ROW_TOP;
            col_d = (colIdx == COL_LAST) ? 4'd0 : colIdx + 4'd1;
          end else begin
            row_d = rowIdx - 3'd1;
          end
          if (cnt_d == CELLS8) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // scan state and indices
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      colIdx  <= 4'd0;
      rowIdx  <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      colIdx  <= col_d;
      rowIdx  <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // refire cooldown, reloaded on each player spawn
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cd_q <= 8'd0;
    end else if (p_go) begin
      cd_q <= CD_RELOAD;
    end else if (startOfFrame && cd_q != 8'd0) begin
      cd_q <= cd_q - 8'd1;
    end
  end

  // slot flags: kills always apply, spawns set a free slot
  always_ff @(posedge clk) begin
    if (!resetN) begin
      activePlayer <= '0;
      activeAlien  <= '0;
    end else begin
      activePlayer <= (activePlayer & ~pKill) | p_set;
      activeAlien  <= (activeAlien & ~aKill) | a_set;
    end
  end

  // spawn strobe and held spawn parameters
  always_ff @(posedge clk) begin
    if (!resetN) begin
      spawnValid   <= 1'b0;
      spawnIsAlien <= 1'b0;
      spawnIdx     <= 3'd0;
      initialX     <= '0;
      initialY     <= '0;
      initialSpeed <= '0;
    end else begin
      spawnValid <= p_go | a_go;
      if (p_go) begin
        spawnIsAlien <= 1'b0;
        spawnIdx     <= p_idx;
        initialX     <= px;
        initialY     <= playerTLY;
        initialSpeed <= PSPD11;
      end else if (a_go) begin
        spawnIsAlien <= 1'b1;
        spawnIdx     <= a_idx;
        initialX     <= ax;
        initialY     <= ay;
        initialSpeed <= aspd;
      end
    end
  end

  assign scanBusy = (state_q == SCAN);

endmodule
